tlb_multiport: RTL and testbench

Parametrised, multi-channel successor to the single-port combinational TLB in the MMU. It serves PORT_COUNT independent translation channels (instruction fetch and data access in the default build) with a registered one-cycle lookup. It adds per-entry valid bits with reset and flush, a hardware Random/Wired replacement counter, a probe/read/write command handshake for CP0, and multi-hit detection. It sits between the pipeline's address-generation stages and the cache/bus interface, with CP0 driving the management port.

---
 rtl/tlb_multiport_pkg.sv | 37 +++
 rtl/tlb_multiport_match_encoder.sv | 26 ++
 rtl/tlb_multiport.sv | 198 +++++++++++++++++++
 tb/tb_tlb_multiport.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tlb_multiport_pkg.sv
// Shared definitions for the multi-port TLB: command encodings, mask kinds,
// probe miss flag and the stored entry layout.
package tlb_multiport_pkg;

    localparam logic [2:0] OP_NOP           = 3'd0;
    localparam logic [2:0] OP_PROBE         = 3'd1;
    localparam logic [2:0] OP_READ          = 3'd2;
    localparam logic [2:0] OP_WRITE_INDEXED = 3'd3;
    localparam logic [2:0] OP_WRITE_RANDOM  = 3'd4;
    localparam logic [2:0] OP_FLUSH         = 3'd5;
    localparam logic [2:0] OP_SET_WIRED     = 3'd6;

    localparam int unsigned MASK_KIND_COUNT = 9;
    localparam int unsigned MASK_WIDTH      = 16;
    localparam int unsigned PROBE_MISS_BIT  = 31;
    localparam logic [31:0] PROBE_MISS      = 32'h1 << PROBE_MISS_BIT;

    typedef struct packed {
        logic [31:0]           hi;
        logic [31:0]           lo0;
        logic [31:0]           lo1;
        logic [MASK_WIDTH-1:0] mask;
    } tlb_entry_t;

    // Keep PageMask[28:13] only when it is one of the nine legal page sizes.
    function automatic logic [MASK_WIDTH-1:0] norm_mask(input logic [31:0] page_mask);
        logic [MASK_WIDTH-1:0] m;
        m         = page_mask[28:13];
        norm_mask = '0;
        for (int k = 0; k < int'(MASK_KIND_COUNT); k++) begin
            if (m == MASK_WIDTH'((32'd1 << (2 * k)) - 32'd1)) begin
                norm_mask = m;
            end
        end
    endfunction

endpackage

// File: rtl/tlb_multiport_match_encoder.sv
// Priority encoder over a TLB match vector: lowest matching index, any-hit
// and multi-hit flags.
module tlb_match_encoder #(
    parameter int unsigned ENTRY_ADDR_WIDTH = 4
) (
    input  logic [(1 << ENTRY_ADDR_WIDTH)-1:0] i_match,
    output logic [ENTRY_ADDR_WIDTH-1:0]        o_index_c,
    output logic                               o_hit_c,
    output logic                               o_multi_c
);
    localparam int unsigned ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH;

    always_comb begin
        o_index_c = '0;
        for (int i = int'(ENTRY_COUNT) - 1; i >= 0; i--) begin
            if (i_match[i]) begin
                o_index_c = ENTRY_ADDR_WIDTH'(i);
            end
        end
    end

    assign o_hit_c   = |i_match;
    // Clearing the lowest set bit leaves something only if two or more matched.
    assign o_multi_c = |(i_match & (i_match - ENTRY_COUNT'(1)));

endmodule

// File: rtl/tlb_multiport.sv
// Multi-channel TLB with registered one-cycle lookup, valid bits, Random/Wired
// replacement counter and a probe/read/write/flush command port for CP0.
module tlb_multiport
    import tlb_multiport_pkg::*;
#(
    parameter int unsigned ENTRY_ADDR_WIDTH = 4,
    parameter int unsigned PORT_COUNT       = 2,
    parameter int unsigned ASID_WIDTH       = 8
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [PORT_COUNT-1:0]         lookupValid,
    input  logic [32*PORT_COUNT-1:0]      vAddr,
    input  logic [ASID_WIDTH-1:0]         asid,
    output logic [PORT_COUNT-1:0]         respValid,
    output logic [32*PORT_COUNT-1:0]      pAddr,
    output logic [PORT_COUNT-1:0]         hit,
    output logic [PORT_COUNT-1:0]         multiHit,
    output logic [PORT_COUNT-1:0]         bitD,
    output logic [PORT_COUNT-1:0]         bitV,
    output logic [3*PORT_COUNT-1:0]       bitC,
    input  logic                          opValid,
    output logic                          opReady,
    input  logic [2:0]                    op,
    input  logic [31:0]                   entryHiIn,
    input  logic [31:0]                   entryLo0In,
    input  logic [31:0]                   entryLo1In,
    input  logic [31:0]                   pageMaskIn,
    input  logic [31:0]                   index,
    output logic                          opDone,
    output logic [31:0]                   entryHiOut,
    output logic [31:0]                   entryLo0Out,
    output logic [31:0]                   entryLo1Out,
    output logic [31:0]                   pageMaskOut,
    output logic [31:0]                   probeResult,
    output logic [ENTRY_ADDR_WIDTH-1:0]   random,
    output logic [ENTRY_ADDR_WIDTH-1:0]   wired
);
    localparam int unsigned EAW         = ENTRY_ADDR_WIDTH;
    localparam int unsigned ENTRY_COUNT = 1 << ENTRY_ADDR_WIDTH;
    localparam logic [EAW-1:0] LAST_IDX = EAW'(ENTRY_COUNT - 1);

    tlb_entry_t             r_entry [ENTRY_COUNT];
    logic [ENTRY_COUNT-1:0] r_valid;
    logic [EAW-1:0]         r_random;
    logic [EAW-1:0]         r_wired;
    logic                   r_op_ready;

    logic [ENTRY_COUNT-1:0] w_match [PORT_COUNT];
    logic [EAW-1:0]         w_idx [PORT_COUNT];
    logic [PORT_COUNT-1:0]  w_hit;
    logic [PORT_COUNT-1:0]  w_multi;
    logic [31:0]            w_lo [PORT_COUNT];
    logic [31:0]            w_pa [PORT_COUNT];
    logic [ENTRY_COUNT-1:0] w_probe_match;
    logic [EAW-1:0]         w_probe_idx;
    logic                   w_probe_hit;
    logic                   w_probe_multi;
    logic                   w_accept;
    logic                   w_wr_en;
    logic [EAW-1:0]         w_wr_idx;
    logic [EAW-1:0]         w_random_next;
    logic [EAW-1:0]         w_wired_clamp;

    function automatic logic entry_hit(input int e, input logic [31:0] va,
                                       input logic [ASID_WIDTH-1:0] id);
        logic [18:0] m19;
        m19       = {3'b000, r_entry[e].mask};
        entry_hit = r_valid[e]
                    && (((r_entry[e].hi[31:13] ^ va[31:13]) & ~m19) == 19'd0)
                    && ((r_entry[e].lo0[0] && r_entry[e].lo1[0])
                        || (r_entry[e].hi[ASID_WIDTH-1:0] == id));
    endfunction

    always_comb begin
        w_probe_match = '0;
        for (int p = 0; p < int'(PORT_COUNT); p++) begin
            w_match[p] = '0;
            for (int e = 0; e < int'(ENTRY_COUNT); e++) begin
                w_match[p][e] = entry_hit(e, vAddr[32*p +: 32], asid);
            end
        end
        for (int e = 0; e < int'(ENTRY_COUNT); e++) begin
            w_probe_match[e] = entry_hit(e, entryHiIn, entryHiIn[ASID_WIDTH-1:0]);
        end
    end

    for (genvar g = 0; g < int'(PORT_COUNT); g++) begin : g_enc
        tlb_match_encoder #(.ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)) u_enc (
            .i_match   (w_match[g]),
            .o_index_c (w_idx[g]),
            .o_hit_c   (w_hit[g]),
            .o_multi_c (w_multi[g])
        );
    end

    tlb_match_encoder #(.ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)) u_probe_enc (
        .i_match   (w_probe_match),
        .o_index_c (w_probe_idx),
        .o_hit_c   (w_probe_hit),
        .o_multi_c (w_probe_multi)
    );

    // Even/odd select is the first bit above the page offset; PFN fills the rest.
    always_comb begin
        logic [31:0] off;
        logic [31:0] va;
        off = '0;
        va  = '0;
        for (int p = 0; p < int'(PORT_COUNT); p++) begin
            va    = vAddr[32*p +: 32];
            off   = {4'b0000, r_entry[w_idx[p]].mask, 12'hFFF};
            w_lo[p] = (|(va & {off[30:0], 1'b1} & ~off)) ? r_entry[w_idx[p]].lo1
                                                          : r_entry[w_idx[p]].lo0;
            w_pa[p] = ({w_lo[p][25:6], 12'h000} & ~off) | (va & off);
        end
    end

    assign w_accept      = opValid && r_op_ready;
    assign w_wr_en       = w_accept && (op == OP_WRITE_INDEXED || op == OP_WRITE_RANDOM);
    assign w_wr_idx      = (op == OP_WRITE_RANDOM) ? r_random : index[EAW-1:0];
    assign w_random_next = (r_random <= r_wired) ? LAST_IDX : r_random - EAW'(1);
    assign w_wired_clamp = (index >= 32'(ENTRY_COUNT)) ? LAST_IDX : index[EAW-1:0];

    always_ff @(posedge clk) begin
        if (!res && w_wr_en) begin
            r_entry[w_wr_idx] <= '{hi: entryHiIn, lo0: entryLo0In, lo1: entryLo1In,
                                   mask: norm_mask(pageMaskIn)};
        end
    end

    // Lookup result registers; a miss or idle channel reports all zeros.
    always_ff @(posedge clk) begin
        if (res) begin
            respValid <= '0;
            pAddr     <= '0;
            hit       <= '0;
            multiHit  <= '0;
            bitD      <= '0;
            bitV      <= '0;
            bitC      <= '0;
        end else begin
            respValid <= lookupValid;
            for (int p = 0; p < int'(PORT_COUNT); p++) begin
                hit[p]          <= lookupValid[p] && w_hit[p];
                multiHit[p]     <= lookupValid[p] && w_hit[p] && w_multi[p];
                bitD[p]         <= lookupValid[p] && w_hit[p] && w_lo[p][2];
                bitV[p]         <= lookupValid[p] && w_hit[p] && w_lo[p][1];
                bitC[3*p +: 3]  <= (lookupValid[p] && w_hit[p]) ? w_lo[p][5:3] : 3'b000;
                pAddr[32*p +: 32] <= (lookupValid[p] && w_hit[p]) ? w_pa[p] : 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_valid     <= '0;
            r_random    <= LAST_IDX;
            r_wired     <= '0;
            r_op_ready  <= 1'b1;
            opDone      <= 1'b0;
            entryHiOut  <= '0;
            entryLo0Out <= '0;
            entryLo1Out <= '0;
            pageMaskOut <= '0;
            probeResult <= PROBE_MISS;
        end else begin
            r_random   <= w_random_next;
            r_op_ready <= !(w_wr_en || (w_accept && op == OP_FLUSH));
            opDone     <= w_accept;
            if (w_wr_en) begin
                r_valid[w_wr_idx] <= 1'b1;
            end
            if (w_accept) begin
                case (op)
                    OP_PROBE: probeResult <= w_probe_hit ? 32'(w_probe_idx) : PROBE_MISS;
                    OP_READ: begin
                        entryHiOut  <= r_entry[index[EAW-1:0]].hi;
                        entryLo0Out <= r_entry[index[EAW-1:0]].lo0;
                        entryLo1Out <= r_entry[index[EAW-1:0]].lo1;
                        pageMaskOut <= {3'b000, r_entry[index[EAW-1:0]].mask, 13'h0};
                    end
                    OP_FLUSH: r_valid <= '0;
                    OP_SET_WIRED: begin
                        r_wired  <= w_wired_clamp;
                        r_random <= LAST_IDX;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign opReady = r_op_ready;
    assign random  = r_random;
    assign wired   = r_wired;

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed-vector bench for tlb_multiport (16 entries, 2 channels, 8-bit ASID).
module tb_tlb_multiport;
    import tlb_multiport_pkg::*;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [1:0]  lookupValid = '0;
    logic [63:0] vAddr = '0;
    logic [7:0]  asid = 8'd7;
    logic [1:0]  respValid, hit, multiHit, bitD, bitV;
    logic [63:0] pAddr;
    logic [5:0]  bitC;
    logic        opValid = 1'b0;
    logic        opReady, opDone;
    logic [2:0]  op = '0;
    logic [31:0] entryHiIn = '0, entryLo0In = '0, entryLo1In = '0, pageMaskIn = '0, index = '0;
    logic [31:0] entryHiOut, entryLo0Out, entryLo1Out, pageMaskOut, probeResult;
    logic [3:0]  random, wired;

    int total = 0;
    int bad   = 0;

    tlb_multiport dut (
        .clk(clk), .res(res), .lookupValid(lookupValid), .vAddr(vAddr), .asid(asid),
        .respValid(respValid), .pAddr(pAddr), .hit(hit), .multiHit(multiHit),
        .bitD(bitD), .bitV(bitV), .bitC(bitC), .opValid(opValid), .opReady(opReady),
        .op(op), .entryHiIn(entryHiIn), .entryLo0In(entryLo0In), .entryLo1In(entryLo1In),
        .pageMaskIn(pageMaskIn), .index(index), .opDone(opDone), .entryHiOut(entryHiOut),
        .entryLo0Out(entryLo0Out), .entryLo1Out(entryLo1Out), .pageMaskOut(pageMaskOut),
        .probeResult(probeResult), .random(random), .wired(wired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (opReady !== 1'b1 && n < 4) begin
            step();
            n++;
        end
        if (opReady !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL op_ready_timeout got=%b want=1", opReady);
        end
    endtask

    task automatic drive_op(input logic [2:0] o, input logic [31:0] hi, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [31:0] pm, input logic [31:0] idx);
        op = o; entryHiIn = hi; entryLo0In = lo0; entryLo1In = lo1; pageMaskIn = pm; index = idx;
        opValid = 1'b1;
    endtask

    task automatic issue_op(input logic [2:0] o, input logic [31:0] hi, input logic [31:0] lo0,
                            input logic [31:0] lo1, input logic [31:0] pm, input logic [31:0] idx);
        wait_ready();
        drive_op(o, hi, lo0, lo1, pm, idx);
        step();
        opValid = 1'b0;
    endtask

    task automatic lookup(input logic [1:0] lv, input logic [31:0] va0, input logic [31:0] va1);
        lookupValid = lv;
        vAddr = {va1, va0};
        step();
        lookupValid = '0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        step();
        step();
        total++; if (respValid !== 2'b00) begin bad++; $display("FAIL reset_respValid got=%b want=00", respValid); end
        total++; if (pAddr !== 64'h0) begin bad++; $display("FAIL reset_pAddr got=%h want=0", pAddr); end
        total++; if (opReady !== 1'b1 || opDone !== 1'b0) begin bad++; $display("FAIL reset_op got ready=%b done=%b want 1/0", opReady, opDone); end
        total++; if (probeResult !== 32'h8000_0000) begin bad++; $display("FAIL reset_probe got=%h want=80000000", probeResult); end
        total++; if (random !== 4'd15 || wired !== 4'd0) begin bad++; $display("FAIL reset_rw got random=%0d wired=%0d want 15/0", random, wired); end
        total++; if (entryHiOut !== 32'h0 || pageMaskOut !== 32'h0) begin bad++; $display("FAIL reset_read got hi=%h pm=%h want 0", entryHiOut, pageMaskOut); end
        res = 1'b0;
    endtask

    task automatic test_miss();
        lookup(2'b01, 32'h0040_0000, 32'h0);
        total++; if (respValid !== 2'b01) begin bad++; $display("FAIL miss_resp got=%b want=01", respValid); end
        total++; if (hit !== 2'b00 || pAddr[31:0] !== 32'h0) begin bad++; $display("FAIL miss_hit got hit=%b pa=%h want 00/0", hit, pAddr[31:0]); end
        step();
        total++; if (respValid !== 2'b00) begin bad++; $display("FAIL miss_resp_drop got=%b want=00", respValid); end
    endtask

    task automatic test_basic_hit();
        wait_ready();
        drive_op(OP_WRITE_INDEXED, 32'h0040_0005, 32'h0000_1017, 32'h0000_0001, 32'h0, 32'd2);
        lookupValid = 2'b01; vAddr = {32'h0, 32'h0040_0123};
        step();
        total++; if (opDone !== 1'b1 || opReady !== 1'b0) begin bad++; $display("FAIL write_handshake got done=%b ready=%b want 1/0", opDone, opReady); end
        total++; if (hit[0] !== 1'b0 || respValid[0] !== 1'b1) begin bad++; $display("FAIL same_edge_old got hit=%b resp=%b want 0/1", hit[0], respValid[0]); end
        // Command offered during the bubble must be ignored.
        drive_op(OP_SET_WIRED, 32'h0, 32'h0, 32'h0, 32'h0, 32'd5);
        step();
        opValid = 1'b0; lookupValid = 2'b00;
        total++; if (hit[0] !== 1'b1 || pAddr[31:0] !== 32'h0004_0123) begin bad++; $display("FAIL basic_hit got hit=%b pa=%h want 1/00040123", hit[0], pAddr[31:0]); end
        total++; if (bitC[2:0] !== 3'd2 || bitD[0] !== 1'b1 || bitV[0] !== 1'b1 || multiHit[0] !== 1'b0) begin bad++; $display("FAIL basic_flags got C=%0d D=%b V=%b M=%b want 2/1/1/0", bitC[2:0], bitD[0], bitV[0], multiHit[0]); end
        total++; if (opDone !== 1'b0 || wired !== 4'd0 || opReady !== 1'b1) begin bad++; $display("FAIL bubble_ignore got done=%b wired=%0d ready=%b want 0/0/1", opDone, wired, opReady); end
        // Non-global entry only matches its own ASID.
        issue_op(OP_WRITE_INDEXED, 32'h0080_0005, 32'h0000_201E, 32'h0000_0006, 32'h0, 32'd5);
        lookup(2'b01, 32'h0080_0000, 32'h0);
        total++; if (hit[0] !== 1'b0) begin bad++; $display("FAIL asid_mismatch got hit=%b want 0", hit[0]); end
        asid = 8'd5;
        lookup(2'b01, 32'h0080_0000, 32'h0);
        total++; if (hit[0] !== 1'b1 || pAddr[31:0] !== 32'h0008_0000 || bitC[2:0] !== 3'd3) begin bad++; $display("FAIL asid_match got hit=%b pa=%h C=%0d want 1/00080000/3", hit[0], pAddr[31:0], bitC[2:0]); end
        asid = 8'd7;
    endtask

    task automatic test_16k_dual();
        issue_op(OP_WRITE_INDEXED, 32'h1000_0005, 32'h0000_4017, 32'h0000_8117, 32'h0000_6000, 32'd3);
        lookup(2'b11, 32'h1000_4010, 32'h1000_0010);
        total++; if (hit !== 2'b11 || respValid !== 2'b11) begin bad++; $display("FAIL dual_hit got hit=%b resp=%b want 11/11", hit, respValid); end
        total++; if (pAddr[31:0] !== 32'h0020_4010) begin bad++; $display("FAIL dual_odd got=%h want=00204010", pAddr[31:0]); end
        total++; if (pAddr[63:32] !== 32'h0010_0010) begin bad++; $display("FAIL dual_even got=%h want=00100010", pAddr[63:32]); end
        issue_op(OP_READ, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3);
        total++; if (pageMaskOut !== 32'h0000_6000 || entryLo0Out !== 32'h0000_4017) begin bad++; $display("FAIL read_16k got pm=%h lo0=%h want 00006000/00004017", pageMaskOut, entryLo0Out); end
        issue_op(OP_WRITE_INDEXED, 32'h1000_0005, 32'h0000_4017, 32'h0000_8117, 32'h0000_2000, 32'd3);
        issue_op(OP_READ, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3);
        total++; if (pageMaskOut !== 32'h0 || entryHiOut !== 32'h1000_0005 || entryLo1Out !== 32'h0000_8117) begin bad++; $display("FAIL read_illegal got pm=%h hi=%h lo1=%h want 0/10000005/00008117", pageMaskOut, entryHiOut, entryLo1Out); end
        lookup(2'b10, 32'h0, 32'h1000_4010);
        total++; if (hit[1] !== 1'b0 || pAddr[63:32] !== 32'h0) begin bad++; $display("FAIL illegal_4k_miss got hit=%b pa=%h want 0/0", hit[1], pAddr[63:32]); end
    endtask

    task automatic test_probe_multi();
        issue_op(OP_WRITE_INDEXED, 32'h2000_0005, 32'h0000_C017, 32'h0000_0001, 32'h0, 32'd1);
        issue_op(OP_WRITE_INDEXED, 32'h2000_0005, 32'h0001_0017, 32'h0000_0001, 32'h0, 32'd4);
        issue_op(OP_PROBE, 32'h2000_0005, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (probeResult !== 32'd1 || opDone !== 1'b1) begin bad++; $display("FAIL probe_hit got=%h done=%b want 00000001/1", probeResult, opDone); end
        lookup(2'b10, 32'h0, 32'h2000_0ABC);
        total++; if (hit[1] !== 1'b1 || multiHit[1] !== 1'b1 || pAddr[63:32] !== 32'h0030_0ABC) begin bad++; $display("FAIL multi_hit got hit=%b multi=%b pa=%h want 1/1/00300abc", hit[1], multiHit[1], pAddr[63:32]); end
        issue_op(OP_FLUSH, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (opDone !== 1'b1 || opReady !== 1'b0) begin bad++; $display("FAIL flush_handshake got done=%b ready=%b want 1/0", opDone, opReady); end
        issue_op(OP_PROBE, 32'h2000_0005, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (probeResult !== 32'h8000_0000) begin bad++; $display("FAIL probe_after_flush got=%h want=80000000", probeResult); end
        lookup(2'b01, 32'h0040_0123, 32'h0);
        total++; if (hit[0] !== 1'b0 || pAddr[31:0] !== 32'h0) begin bad++; $display("FAIL flush_lookup got hit=%b pa=%h want 0/0", hit[0], pAddr[31:0]); end
    endtask

    task automatic test_random_wired();
        logic [3:0] exp_r;
        logic [3:0] sampled;
        int         errs = 0;
        issue_op(OP_SET_WIRED, 32'h0, 32'h0, 32'h0, 32'h0, 32'd3);
        total++; if (random !== 4'd15 || wired !== 4'd3) begin bad++; $display("FAIL set_wired got random=%0d wired=%0d want 15/3", random, wired); end
        exp_r = 4'd15;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_r = (exp_r == 4'd3) ? 4'd15 : exp_r - 4'd1;
            if (random !== exp_r || random < 4'd3) begin
                errs++;
                if (errs == 1) $display("FAIL random_seq cycle=%0d got=%0d want=%0d", i, random, exp_r);
            end
        end
        total++; if (errs != 0) bad++;
        wait_ready();
        sampled = random;
        drive_op(OP_WRITE_RANDOM, 32'h3000_0005, 32'h0000_0017, 32'h0000_0001, 32'h0, 32'h0);
        step();
        opValid = 1'b0;
        exp_r = (sampled == 4'd3) ? 4'd15 : sampled - 4'd1;
        total++; if (random !== exp_r || sampled < 4'd3) begin bad++; $display("FAIL random_after_write got=%0d want=%0d sampled=%0d", random, exp_r, sampled); end
        issue_op(OP_PROBE, 32'h3000_0005, 32'h0, 32'h0, 32'h0, 32'h0);
        total++; if (probeResult !== {28'h0, sampled}) begin bad++; $display("FAIL write_random_index got=%h want=%h", probeResult, {28'h0, sampled}); end
        issue_op(OP_SET_WIRED, 32'h0, 32'h0, 32'h0, 32'h0, 32'd100);
        step();
        step();
        total++; if (wired !== 4'd15 || random !== 4'd15) begin bad++; $display("FAIL wired_clamp got wired=%0d random=%0d want 15/15", wired, random); end
    endtask

    task automatic test_reset_mid();
        issue_op(OP_WRITE_INDEXED, 32'h4000_0005, 32'h0000_0017, 32'h0000_0001, 32'h0, 32'd6);
        wait_ready();
        drive_op(OP_WRITE_INDEXED, 32'h4000_0005, 32'h0000_0017, 32'h0000_0001, 32'h0, 32'd7);
        step();
        opValid = 1'b0;
        res = 1'b1;
        lookupValid = 2'b11; vAddr = {32'h4000_0000, 32'h4000_0000};
        step();
        res = 1'b0; lookupValid = 2'b00;
        total++; if (opDone !== 1'b0 || respValid !== 2'b00 || opReady !== 1'b1) begin bad++; $display("FAIL mid_reset_op got done=%b resp=%b ready=%b want 0/00/1", opDone, respValid, opReady); end
        total++; if (random !== 4'd15 || wired !== 4'd0) begin bad++; $display("FAIL mid_reset_rw got random=%0d wired=%0d want 15/0", random, wired); end
        lookup(2'b11, 32'h4000_0000, 32'h4000_0000);
        total++; if (hit !== 2'b00 || respValid !== 2'b11 || pAddr !== 64'h0) begin bad++; $display("FAIL mid_reset_miss got hit=%b resp=%b pa=%h want 00/11/0", hit, respValid, pAddr); end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_basic_hit();
        test_16k_dual();
        test_probe_multi();
        test_random_wired();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
